seq_loader: RTL and testbench

SEQ_LOADER -- requirements
Module: seq_loader

---
 rtl/seq_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_seq_loader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_loader.sv
`default_nettype none
// ============================================================================
// seq_loader: assembles cmd/beat streams into bank records and penalty loads.
// Optional issue counters enabled by SEQ_LOADER_CNT_EN.      Revision: 1.0
// ============================================================================
module seq_loader #(
  parameter int         ID_WIDTH      = 48,
  parameter int         LEN_WIDTH     = 12,
  parameter int         TARGET_LENGTH = 128,
  parameter int         SCORE_WIDTH   = 12,
  parameter int         BPB           = 16,
  parameter logic [1:0] PAD           = 2'b00,
  parameter int         IN_WIDTH      = 2 + ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_type,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [2*BPB-1:0]         s_data,
  input  logic                     s_last,
  input  logic                     pen_valid,
  output logic                     pen_ready,
  input  logic [4*SCORE_WIDTH-1:0] pen_data,
  input  logic                     full,
  output logic                     ld_sequence,
  output logic [IN_WIDTH-1:0]      data_in,
  output logic                     ld_penalties,
  output logic [4*SCORE_WIDTH-1:0] penalties,
  output logic                     err,
  output logic [15:0]              tgt_cnt,
  output logic [15:0]              qry_cnt
);

  localparam int c_SEQ_W     = 2*TARGET_LENGTH;
  localparam int c_MAX_BEATS = (TARGET_LENGTH + BPB - 1) / BPB;
  localparam int c_BW        = $clog2(c_MAX_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    DRAIN = 3'd2,
    WAIT  = 3'd3,
    PEN   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_type;
  logic [ID_WIDTH-1:0]  r_id;
  logic [LEN_WIDTH-1:0] r_len;
  logic [c_SEQ_W-1:0]   r_seq;
  logic [c_BW-1:0]      r_beat_cnt;
  logic [c_BW-1:0]      r_exp;

  logic [LEN_WIDTH-1:0] w_len_eff;
  logic [LEN_WIDTH:0]   w_len_rnd;
  logic [c_BW-1:0]      w_beat_inc;
  logic                 w_cnt_hit;
  logic [c_SEQ_W-1:0]   w_seq_nxt;

  logic                 w_pen_acc;
  logic                 w_cmd_acc;
  logic                 w_beat_acc;
  logic                 w_err_set;
  logic                 w_to_wait;

  assign w_len_eff  = (cmd_len > LEN_WIDTH'(TARGET_LENGTH)) ? LEN_WIDTH'(TARGET_LENGTH) : cmd_len;
  assign w_len_rnd  = {1'b0, w_len_eff} + (LEN_WIDTH+1)'(BPB - 1);
  assign w_beat_inc = r_beat_cnt + c_BW'(1);
  assign w_cnt_hit  = (w_beat_inc == r_exp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready    = 1'b0;
    pen_ready    = 1'b0;
    s_ready      = 1'b0;
    ld_sequence  = 1'b0;
    ld_penalties = 1'b0;
    w_pen_acc    = 1'b0;
    w_cmd_acc    = 1'b0;
    w_beat_acc   = 1'b0;
    w_err_set    = 1'b0;
    w_to_wait    = 1'b0;
    case (r_state)
      IDLE: begin
        pen_ready = 1'b1;
        // Withhold cmd_ready so a simultaneous command is not handshaken.
        cmd_ready = ~pen_valid;
        if (pen_valid) begin
          w_pen_acc   = 1'b1;
          w_state_nxt = PEN;
        end else if (cmd_valid) begin
          w_cmd_acc   = 1'b1;
          w_err_set   = (cmd_len > LEN_WIDTH'(TARGET_LENGTH));
          w_state_nxt = (w_len_eff == '0) ? DRAIN : FILL;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_beat_acc = 1'b1;
          if (s_last) begin
            w_err_set   = ~w_cnt_hit;
            w_to_wait   = 1'b1;
            w_state_nxt = WAIT;
          end else if (w_cnt_hit) begin
            w_err_set   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          w_to_wait   = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_type || !full) begin
          ld_sequence = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      PEN: begin
        ld_penalties = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A reset cycle never handshakes or strobes.
    if (!rst) begin
      cmd_ready    = 1'b0;
      pen_ready    = 1'b0;
      s_ready      = 1'b0;
      ld_sequence  = 1'b0;
      ld_penalties = 1'b0;
      w_pen_acc    = 1'b0;
      w_cmd_acc    = 1'b0;
      w_beat_acc   = 1'b0;
      w_err_set    = 1'b0;
      w_to_wait    = 1'b0;
    end
  end

  // Only bases below the clamped length are written; the rest keep PAD.
  always_comb begin
    w_seq_nxt = r_seq;
    for (int i = 0; i < TARGET_LENGTH; i++) begin
      if (w_beat_acc && (int'(r_beat_cnt) == i / BPB) && (int'(r_len) > i)) begin
        w_seq_nxt[c_SEQ_W-1-2*i -: 2] = s_data[2*BPB-1-2*(i % BPB) -: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_type     <= 1'b0;
      r_id       <= '0;
      r_len      <= '0;
      r_seq      <= {TARGET_LENGTH{PAD}};
      r_beat_cnt <= '0;
      r_exp      <= '0;
      data_in    <= '0;
      penalties  <= '0;
      err        <= 1'b0;
    end else begin
      err <= w_err_set;
      if (w_pen_acc) begin
        penalties <= pen_data;
      end
      if (w_cmd_acc) begin
        r_type     <= cmd_type;
        r_id       <= cmd_id;
        r_len      <= w_len_eff;
        r_seq      <= {TARGET_LENGTH{PAD}};
        r_beat_cnt <= '0;
        r_exp      <= c_BW'(w_len_rnd / (LEN_WIDTH+1)'(BPB));
      end else if (w_beat_acc) begin
        r_seq      <= w_seq_nxt;
        r_beat_cnt <= w_beat_inc;
      end
      // Loaded from the next-sequence view so the final beat lands here too.
      if (w_to_wait) begin
        data_in <= {~r_type, r_type, r_id, r_len, w_seq_nxt};
      end
    end
  end

`ifdef SEQ_LOADER_CNT_EN
  logic [15:0] r_tgt_cnt;
  logic [15:0] r_qry_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tgt_cnt <= '0;
      r_qry_cnt <= '0;
    end else if (ld_sequence) begin
      if (r_type) begin
        r_qry_cnt <= r_qry_cnt + 16'd1;
      end else begin
        r_tgt_cnt <= r_tgt_cnt + 16'd1;
      end
    end
  end

  assign tgt_cnt = r_tgt_cnt;
  assign qry_cnt = r_qry_cnt;
`else
  assign tgt_cnt = 16'd0;
  assign qry_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_loader.sv
`default_nettype none
// tb_seq_loader: directed and randomized records checked against a base-array model.
module tb_seq_loader;
  localparam int ID_W  = 48;
  localparam int LEN_W = 12;
  localparam int TL    = 128;
  localparam int SW    = 12;
  localparam int BPB   = 16;
  localparam int IN_W  = 2 + ID_W + LEN_W + 2*TL;
`ifdef SEQ_LOADER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_type = 1'b0;
  logic [ID_W-1:0]   cmd_id = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [2*BPB-1:0]  s_data = '0;
  logic              pen_valid = 1'b0, pen_ready;
  logic [4*SW-1:0]   pen_data = '0;
  logic              full = 1'b0;
  logic              ld_sequence, ld_penalties, err;
  logic [IN_W-1:0]   data_in;
  logic [4*SW-1:0]   penalties;
  logic [15:0]       tgt_cnt, qry_cnt;

  seq_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_id(cmd_id), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .pen_valid(pen_valid), .pen_ready(pen_ready), .pen_data(pen_data),
    .full(full), .ld_sequence(ld_sequence), .data_in(data_in),
    .ld_penalties(ld_penalties), .penalties(penalties), .err(err),
    .tgt_cnt(tgt_cnt), .qry_cnt(qry_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            ld_cyc_q[$];
  logic [IN_W-1:0] ld_data_q[$];
  int            err_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            exp_tgt = 0;
  int            exp_qry = 0;

  always @(negedge clk) begin
    if (ld_sequence === 1'b1) begin
      ld_cyc_q.push_back(cyc);
      ld_data_q.push_back(data_in);
    end
    if (err === 1'b1) err_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ID_W-1:0] rand_id();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[ID_W-1:0];
  endfunction

  task automatic send_cmd(input logic t, input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_type = t; cmd_id = id; cmd_len = len;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++; n_err++;
      $display("FAIL cmd_handshake: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [2*BPB-1:0] d, input logic last, output int acc);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++; n_err++;
      $display("FAIL beat_handshake: s_ready=%b required 1 within 100 cycles", s_ready);
    end
    tick();
    acc = cyc;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    logic [15:0] et, eq;
    et = CNT_EN ? 16'(exp_tgt) : 16'd0;
    eq = CNT_EN ? 16'(exp_qry) : 16'd0;
    @(negedge clk);
    n_vec++;
    if (tgt_cnt !== et) begin
      n_err++;
      $display("FAIL %s tgt_cnt: got %0d expected %0d", tag, tgt_cnt, et);
    end
    n_vec++;
    if (qry_cnt !== eq) begin
      n_err++;
      $display("FAIL %s qry_cnt: got %0d expected %0d", tag, qry_cnt, eq);
    end
    tick();
  endtask

  // One record: command, nb beats (s_last on the final one), optional full stall.
  task automatic run_record(input string tag, input logic t, input logic [ID_W-1:0] id,
                            input logic [LEN_W-1:0] len, input int nb, input int stall);
    logic [1:0]       bases [TL];
    logic [2*BPB-1:0] beat;
    logic [2*TL-1:0]  seq;
    logic [IN_W-1:0]  exp_data;
    int len_eff, exp_beats, exp_err, acc, exp_cyc;
    len_eff   = (len > LEN_W'(TL)) ? TL : int'(len);
    exp_beats = (len_eff + BPB - 1) / BPB;
    exp_err   = (len > LEN_W'(TL)) ? 1 : 0;
    if (exp_beats != 0 && nb != exp_beats) exp_err++;
    for (int g = 0; g < TL; g++) bases[g] = 2'b00;
    ld_cyc_q.delete(); ld_data_q.delete(); err_q.delete();
    full = (stall > 0);
    acc = 0;
    send_cmd(t, id, len);
    for (int k = 0; k < nb; k++) begin
      beat = $urandom;
      for (int j = 0; j < BPB; j++)
        if (k < exp_beats && k*BPB + j < len_eff) bases[k*BPB + j] = beat[2*BPB-1-2*j -: 2];
      send_beat(beat, k == nb - 1, acc);
    end
    exp_cyc = acc;
    if (!t) begin
      exp_cyc = acc + stall;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        n_vec++;
        if (ld_sequence !== 1'b0 || cmd_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s stall: ld_sequence=%b cmd_ready=%b required 0/0", tag, ld_sequence, cmd_ready);
        end
        tick();
      end
      full = 1'b0;
    end
    repeat (3) tick();
    full = 1'b0;
    for (int g = 0; g < TL; g++) seq[2*TL-1-2*g -: 2] = bases[g];
    exp_data = {(t ? 2'b01 : 2'b10), id, LEN_W'(len_eff), seq};
    if (t) exp_qry++; else exp_tgt++;
    n_vec++;
    if (ld_cyc_q.size() != 1) begin
      n_err++;
      $display("FAIL %s ld_count: got %0d pulses expected 1", tag, ld_cyc_q.size());
    end else begin
      n_vec++;
      if (ld_cyc_q[0] != exp_cyc) begin
        n_err++;
        $display("FAIL %s ld_latency: got cycle %0d expected %0d", tag, ld_cyc_q[0], exp_cyc);
      end
      n_vec++;
      if (ld_data_q[0] !== exp_data) begin
        n_err++;
        $display("FAIL %s data_in: got %h expected %h", tag, ld_data_q[0], exp_data);
      end
    end
    n_vec++;
    if (err_q.size() != exp_err) begin
      n_err++;
      $display("FAIL %s err_count: got %0d expected %0d", tag, err_q.size(), exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    exp_tgt = 0; exp_qry = 0;
    @(negedge clk);
    n_vec++;
    if ({ld_sequence, ld_penalties, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset strobes: got %b expected 000", {ld_sequence, ld_penalties, err});
    end
    n_vec++;
    if (data_in !== '0 || penalties !== '0) begin
      n_err++;
      $display("FAIL reset regs: data_in=%h penalties=%h expected 0", data_in, penalties);
    end
    n_vec++;
    if ({cmd_ready, pen_ready, s_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL reset ready: got %b expected 110", {cmd_ready, pen_ready, s_ready});
    end
    tick();
    check_counters("reset");
  endtask

  task automatic test_basic_target();
    run_record("target_len32", 1'b0, 48'h1234_5678_9ABC, 12'd32, 2, 0);
  endtask

  task automatic test_query_pad();
    run_record("query_len20_full", 1'b1, rand_id(), 12'd20, 2, 3);
  endtask

  task automatic test_full_stall();
    run_record("target_stall10", 1'b0, rand_id(), 12'd64, 4, 10);
  endtask

  task automatic test_len_errors();
    run_record("len16_drain", 1'b0, rand_id(), 12'd16, 3, 0);
    run_record("len48_early", 1'b1, rand_id(), 12'd48, 1, 0);
    run_record("len200_clamp", 1'b0, rand_id(), 12'd200, 10, 0);
    run_record("len0", 1'b1, rand_id(), 12'd0, 2, 0);
    run_record("len128_exact", 1'b0, rand_id(), 12'd128, 8, 0);
    run_record("len100_partial", 1'b1, rand_id(), 12'd100, 7, 0);
  endtask

  task automatic test_penalty_priority();
    logic [63:0] r;
    logic [4*SW-1:0] pd;
    logic [2*BPB-1:0] d;
    logic [IN_W-1:0] exp_data;
    int a, acc;
    r = {$urandom, $urandom};
    pd = r[4*SW-1:0];
    ld_cyc_q.delete(); ld_data_q.delete();
    pen_valid = 1'b1; pen_data = pd;
    cmd_valid = 1'b1; cmd_type = 1'b1; cmd_id = '0; cmd_len = 12'd16;
    @(negedge clk);
    n_vec++;
    if (pen_ready !== 1'b1 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pen_prio ready: pen_ready=%b cmd_ready=%b expected 1/0", pen_ready, cmd_ready);
    end
    tick();
    pen_valid = 1'b0;
    a = cyc;
    @(negedge clk);
    n_vec++;
    if (ld_penalties !== 1'b1 || penalties !== pd) begin
      n_err++;
      $display("FAIL pen_load: ld_penalties=%b penalties=%h expected 1/%h", ld_penalties, penalties, pd);
    end
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pen_state cmd_ready: got %b expected 0", cmd_ready);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (ld_penalties !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pen_after: ld_penalties=%b cmd_ready=%b expected 0/1", ld_penalties, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if (cyc != a + 2) begin
      n_err++;
      $display("FAIL cmd_accept_cycle: got %0d expected %0d", cyc, a + 2);
    end
    d = $urandom;
    send_beat(d, 1'b1, acc);
    repeat (3) tick();
    exp_qry++;
    exp_data = {2'b01, 48'h0, 12'd16, d, 224'h0};
    n_vec++;
    if (ld_data_q.size() != 1) begin
      n_err++;
      $display("FAIL pen_record ld_count: got %0d expected 1", ld_data_q.size());
    end else if (ld_data_q[0] !== exp_data) begin
      n_err++;
      $display("FAIL pen_record data_in: got %h expected %h", ld_data_q[0], exp_data);
    end
  endtask

  task automatic test_reset_mid_fill();
    int acc;
    ld_cyc_q.delete(); ld_data_q.delete(); err_q.delete();
    send_cmd(1'b0, rand_id(), 12'd64);
    send_beat($urandom, 1'b0, acc);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_tgt = 0; exp_qry = 0;
    repeat (4) tick();
    @(negedge clk);
    n_vec++;
    if (ld_cyc_q.size() != 0 || err_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_fill strobes: ld=%0d err=%0d expected 0/0", ld_cyc_q.size(), err_q.size());
    end
    n_vec++;
    if (cmd_ready !== 1'b1 || s_ready !== 1'b0 || data_in !== '0) begin
      n_err++;
      $display("FAIL reset_mid_fill state: cmd_ready=%b s_ready=%b data_in=%h expected 1/0/0",
               cmd_ready, s_ready, data_in);
    end
    tick();
    check_counters("after_reset");
  endtask

  task automatic test_counters();
    for (int i = 0; i < 3; i++) run_record("cnt_target", 1'b0, rand_id(), 12'd16, 1, 0);
    for (int i = 0; i < 2; i++) run_record("cnt_query", 1'b1, rand_id(), 12'd16, 1, 0);
    check_counters("counters_3t2q");
  endtask

  task automatic test_random();
    logic t;
    logic [LEN_W-1:0] len;
    for (int n = 0; n < 25; n++) begin
      t = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: len = LEN_W'($urandom_range(1, 140));
        1: len = LEN_W'(16 * $urandom_range(1, 8));
        2: len = LEN_W'($urandom_range(129, 300));
        default: len = '0;
      endcase
      run_record("random", t, rand_id(), len, int'($urandom_range(1, 10)), int'($urandom_range(0, 3)));
    end
    check_counters("random_end");
  endtask

  initial begin
    test_reset();
    test_basic_target();
    test_query_pad();
    test_full_stall();
    test_len_errors();
    test_penalty_priority();
    test_reset_mid_fill();
    test_counters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
